// File: rtl/fifo_access_ctrl_if.sv
// Bundle of receiver, host read port and FIFO-side signals for fifo_access_ctrl.
// slave = the controller's view; master = the surrounding integration / bench.
interface fifo_access_ctrl_if #(
    parameter int DATA_BITS     = 8,
    parameter int FIFO_WIDTH    = 4,
    parameter int DROP_CNT_BITS = 8
);
    logic [DATA_BITS-1:0]     Rx_Data;
    logic                     Rx_Valid;
    logic                     Rd_Req;
    logic                     Bist_Req;
    logic [DATA_BITS-1:0]     Fifo_Data_Out;
    logic [DATA_BITS-1:0]     Fifo_Wr_Data;
    logic                     Fifo_Data_Rdy;
    logic                     Fifo_Pop_Data;
    logic                     Fifo_BIST_Mode;
    logic [DATA_BITS-1:0]     Rd_Data;
    logic                     Rd_Valid;
    logic                     Rd_Pending;
    logic                     Hold_Full;
    logic [FIFO_WIDTH:0]      Fifo_Count;
    logic [DROP_CNT_BITS-1:0] Drop_Count;

    modport slave (
        input  Rx_Data, Rx_Valid, Rd_Req, Bist_Req, Fifo_Data_Out,
        output Fifo_Wr_Data, Fifo_Data_Rdy, Fifo_Pop_Data, Fifo_BIST_Mode,
               Rd_Data, Rd_Valid, Rd_Pending, Hold_Full, Fifo_Count, Drop_Count
    );

    modport master (
        output Rx_Data, Rx_Valid, Rd_Req, Bist_Req, Fifo_Data_Out,
        input  Fifo_Wr_Data, Fifo_Data_Rdy, Fifo_Pop_Data, Fifo_BIST_Mode,
               Rd_Data, Rd_Valid, Rd_Pending, Hold_Full, Fifo_Count, Drop_Count
    );
endinterface

// File: rtl/fifo_access_ctrl.sv
// Sequencer turning receiver bytes and host reads into clean FIFO write/pop pulses.
// Optional dropped-byte counter is enabled by defining FIFOCTRL_DROP_CNT_EN.
module fifo_access_ctrl #(
    parameter int DATA_BITS     = 8,
    parameter int FIFO_WIDTH    = 4,
    parameter int DROP_CNT_BITS = 8
) (
    input  logic               clk,
    input  logic               rst,
    fifo_access_ctrl_if.slave  bus
);
    localparam int                  FIFO_ENTRIES = 2**FIFO_WIDTH;
    localparam logic [FIFO_WIDTH:0] FULL_CNT     = FIFO_ENTRIES[FIFO_WIDTH:0];

    typedef enum logic [2:0] {
        IDLE, WR_PULSE, WR_GAP, RD_PULSE, RD_GAP, RD_CAP
    } state_t;

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_t;

    state_t               state, state_next;
    grant_t               last_grant, grant_next;
    logic                 hold_full;
    logic [DATA_BITS-1:0] hold_data;
    logic                 rd_pending;
    logic [FIFO_WIDTH:0]  count;
    logic                 bist_mode;
    logic                 data_rdy;
    logic                 pop_data;
    logic [DATA_BITS-1:0] rd_data;
    logic                 rd_valid;
    logic                 wr_ok;
    logic                 rd_ok;
    logic                 hold_release;
    logic                 rx_take;

    // The hold register frees on WR_GAP exit but may be refilled on that same edge.
    assign hold_release = (state == WR_GAP);
    assign rx_take      = bus.Rx_Valid && (!hold_full || hold_release);

    always_comb begin
        state_next = state;
        grant_next = last_grant;
        wr_ok      = hold_full && (count != FULL_CNT) && !bist_mode;
        rd_ok      = rd_pending && (count != '0) && !bist_mode;
        case (state)
            IDLE: begin
                if (wr_ok && (!rd_ok || last_grant == GRANT_RD)) begin
                    state_next = WR_PULSE;
                    grant_next = GRANT_WR;
                end else if (rd_ok) begin
                    state_next = RD_PULSE;
                    grant_next = GRANT_RD;
                end
            end
            WR_PULSE: state_next = WR_GAP;
            WR_GAP:   state_next = IDLE;
            RD_PULSE: state_next = RD_GAP;
            RD_GAP:   state_next = RD_CAP;
            RD_CAP:   state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GRANT_RD;
            hold_full  <= 1'b0;
            hold_data  <= '0;
            rd_pending <= 1'b0;
            count      <= '0;
            bist_mode  <= 1'b0;
            data_rdy   <= 1'b0;
            pop_data   <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
        end else begin
            state      <= state_next;
            last_grant <= grant_next;
            data_rdy   <= (state_next == WR_PULSE);
            pop_data   <= (state_next == RD_PULSE);
            rd_valid   <= (state == RD_CAP);
            if (state == RD_CAP) begin
                rd_data <= bus.Fifo_Data_Out;
            end
            if (rx_take) begin
                hold_data <= bus.Rx_Data;
                hold_full <= 1'b1;
            end else if (hold_release) begin
                hold_full <= 1'b0;
            end
            if (state == RD_CAP) begin
                rd_pending <= 1'b0;
            end else if (bus.Rd_Req) begin
                rd_pending <= 1'b1;
            end
            if (state == WR_PULSE) begin
                count <= count + 1'b1;
            end else if (state == RD_PULSE) begin
                count <= count - 1'b1;
            end
            // BIST only switches on IDLE cycles that start no transaction.
            if (state == IDLE && state_next == IDLE) begin
                bist_mode <= bus.Bist_Req;
            end
        end
    end

`ifdef FIFOCTRL_DROP_CNT_EN
    logic [DROP_CNT_BITS-1:0] drop_count;
    logic                     rx_drop;

    assign rx_drop = bus.Rx_Valid && !rx_take;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= '0;
        end else if (rx_drop && drop_count != {DROP_CNT_BITS{1'b1}}) begin
            drop_count <= drop_count + 1'b1;
        end
    end

    assign bus.Drop_Count = drop_count;
`else
    assign bus.Drop_Count = {DROP_CNT_BITS{1'b0}};
`endif

    assign bus.Fifo_Wr_Data   = hold_data;
    assign bus.Fifo_Data_Rdy  = data_rdy;
    assign bus.Fifo_Pop_Data  = pop_data;
    assign bus.Fifo_BIST_Mode = bist_mode;
    assign bus.Rd_Data        = rd_data;
    assign bus.Rd_Valid       = rd_valid;
    assign bus.Rd_Pending     = rd_pending;
    assign bus.Hold_Full      = hold_full;
    assign bus.Fifo_Count     = count;
endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Bench for fifo_access_ctrl: directed vector table, hand sequences, and random
// traffic compared against a transaction-level reference model with its own FIFO queue.
module tb_fifo_access_ctrl;
    localparam int DB      = 8;
    localparam int FW      = 4;
    localparam int DCB     = 8;
    localparam int ENTRIES = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_access_ctrl_if #(.DATA_BITS(DB), .FIFO_WIDTH(FW), .DROP_CNT_BITS(DCB)) bus ();

    fifo_access_ctrl #(.DATA_BITS(DB), .FIFO_WIDTH(FW), .DROP_CNT_BITS(DCB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Edge-triggered FIFO stand-in driven by the DUT pulses.
    logic [DB-1:0] fq[$];
    logic [DB-1:0] fdout;
    always @(posedge clk) begin
        if (rst) begin
            fq.delete();
            fdout <= '0;
        end else begin
            if (bus.Fifo_Pop_Data && fq.size() > 0) fdout <= fq.pop_front();
            if (bus.Fifo_Data_Rdy) fq.push_back(bus.Fifo_Wr_Data);
        end
    end
    assign bus.Fifo_Data_Out = fdout;

    // Reference model: a transaction is (kind, cycle index); kind 1 = write, 2 = read.
    bit            m_hold_full, m_pend, m_bist, m_last_rd, m_rdy, m_pop, m_vld;
    logic [DB-1:0] m_hold, m_rdata, m_popped;
    int            m_cnt, m_kind, m_t, m_drop;
    logic [DB-1:0] m_q[$];

    task automatic model_step();
        bit idle, wr_ok, rd_ok, g_wr, g_rd, gap_exit, cap;
        if (rst) begin
            m_hold_full = 0; m_pend = 0; m_bist = 0; m_last_rd = 1;
            m_rdy = 0; m_pop = 0; m_vld = 0; m_hold = '0; m_rdata = '0; m_popped = '0;
            m_cnt = 0; m_kind = 0; m_t = 0; m_drop = 0; m_q.delete();
            return;
        end
        idle     = (m_kind == 0);
        wr_ok    = m_hold_full && m_cnt < ENTRIES && !m_bist;
        rd_ok    = m_pend && m_cnt > 0 && !m_bist;
        g_wr     = idle && wr_ok && (!rd_ok || m_last_rd);
        g_rd     = idle && rd_ok && !g_wr;
        gap_exit = (m_kind == 1 && m_t == 1);
        cap      = (m_kind == 2 && m_t == 2);
        if (m_kind == 1 && m_t == 0) begin m_cnt++; m_q.push_back(m_hold); end
        if (m_kind == 2 && m_t == 0) begin m_cnt--; m_popped = m_q.pop_front(); end
        m_vld = cap;
        if (cap) m_rdata = m_popped;
        if (bus.Rx_Valid && (!m_hold_full || gap_exit)) begin
            m_hold = bus.Rx_Data;
            m_hold_full = 1;
        end else begin
            if (bus.Rx_Valid && m_drop < 255) m_drop++;
            if (gap_exit) m_hold_full = 0;
        end
        if (cap) m_pend = 0;
        else if (bus.Rd_Req) m_pend = 1;
        if (idle && !g_wr && !g_rd) m_bist = bus.Bist_Req;
        if (g_wr) begin m_kind = 1; m_t = 0; m_last_rd = 0; end
        else if (g_rd) begin m_kind = 2; m_t = 0; m_last_rd = 1; end
        else if (m_kind == 1) begin if (m_t == 1) m_kind = 0; else m_t++; end
        else if (m_kind == 2) begin if (m_t == 2) m_kind = 0; else m_t++; end
        m_rdy = (m_kind == 1 && m_t == 0);
        m_pop = (m_kind == 2 && m_t == 0);
    endtask

    function automatic int exp_drop(input int n);
`ifdef FIFOCTRL_DROP_CNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    bit cmp_model = 0;
    bit prev_rdy = 0, prev_pop = 0;

    task automatic compare_model();
        check("m_data_rdy", bus.Fifo_Data_Rdy, m_rdy);
        check("m_pop_data", bus.Fifo_Pop_Data, m_pop);
        check("m_hold_full", bus.Hold_Full, m_hold_full);
        check("m_wr_data", bus.Fifo_Wr_Data, m_hold);
        check("m_rd_pending", bus.Rd_Pending, m_pend);
        check("m_fifo_count", bus.Fifo_Count, m_cnt);
        check("m_rd_valid", bus.Rd_Valid, m_vld);
        check("m_rd_data", bus.Rd_Data, m_rdata);
        check("m_bist_mode", bus.Fifo_BIST_Mode, m_bist);
        check("m_drop_count", bus.Drop_Count, exp_drop(m_drop));
    endtask

    task automatic tick();
        bit ok;
        @(posedge clk);
        model_step();
        #1;
        ok = !(bus.Fifo_Data_Rdy && bus.Fifo_Pop_Data) && !(bus.Fifo_Data_Rdy && prev_rdy) &&
             !(bus.Fifo_Pop_Data && prev_pop) && !(bus.Fifo_Data_Rdy && bus.Fifo_Count >= ENTRIES);
        check("pulse_rules", ok, 1);
        prev_rdy = bus.Fifo_Data_Rdy;
        prev_pop = bus.Fifo_Pop_Data;
        if (cmp_model) compare_model();
    endtask

    task automatic clear_inputs();
        bus.Rx_Valid = 0; bus.Rx_Data = '0; bus.Rd_Req = 0; bus.Bist_Req = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic push(input logic [DB-1:0] b);
        bus.Rx_Valid = 1; bus.Rx_Data = b;
        tick();
        bus.Rx_Valid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_read(input logic [DB-1:0] exp, input string name);
        bit got = 0;
        bus.Rd_Req = 1;
        tick();
        bus.Rd_Req = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            if (bus.Rd_Valid) got = 1;
            else tick();
        end
        if (got) check(name, bus.Rd_Data, exp);
        else check({name, "_timeout"}, got, 1);
    endtask

    typedef struct {
        bit            rst, rxv;
        logic [DB-1:0] rxd;
        bit            rdq, rdy, pop, hold, pend;
        int            cnt;
        bit            vld;
        logic [DB-1:0] rdata;
    } vec_t;

    vec_t tbl[14];

    initial begin
        // rst rxv rxd rdq | rdy pop hold pend cnt vld rdata
        tbl[0]  = '{1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00};
        tbl[1]  = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00};
        tbl[2]  = '{0, 1, 8'hA5, 0, 0, 0, 1, 0, 0, 0, 8'h00};
        tbl[3]  = '{0, 0, 8'h00, 0, 1, 0, 1, 0, 0, 0, 8'h00};
        tbl[4]  = '{0, 0, 8'h00, 0, 0, 0, 1, 0, 1, 0, 8'h00};
        tbl[5]  = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 8'h00};
        tbl[6]  = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 8'h00};
        tbl[7]  = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 8'h00};
        tbl[8]  = '{0, 0, 8'h00, 1, 0, 0, 0, 1, 1, 0, 8'h00};
        tbl[9]  = '{0, 0, 8'h00, 0, 0, 1, 0, 1, 1, 0, 8'h00};
        tbl[10] = '{0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'h00};
        tbl[11] = '{0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'h00};
        tbl[12] = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 8'hA5};
        tbl[13] = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'hA5};

        // Reset then ten idle cycles: every output stays at zero.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_outputs", {bus.Fifo_Data_Rdy, bus.Fifo_Pop_Data, bus.Fifo_BIST_Mode,
                                   bus.Rd_Valid, bus.Rd_Pending, bus.Hold_Full, bus.Rd_Data,
                                   bus.Fifo_Wr_Data, bus.Fifo_Count, bus.Drop_Count}, 0);
        end

        // Single push then read, cycle by cycle.
        for (int i = 0; i < 14; i++) begin
            rst = tbl[i].rst; bus.Rx_Valid = tbl[i].rxv; bus.Rx_Data = tbl[i].rxd;
            bus.Rd_Req = tbl[i].rdq;
            tick();
            rst = 0; bus.Rx_Valid = 0; bus.Rd_Req = 0;
            check($sformatf("v%0d_data_rdy", i), bus.Fifo_Data_Rdy, tbl[i].rdy);
            check($sformatf("v%0d_pop_data", i), bus.Fifo_Pop_Data, tbl[i].pop);
            check($sformatf("v%0d_hold_full", i), bus.Hold_Full, tbl[i].hold);
            check($sformatf("v%0d_rd_pending", i), bus.Rd_Pending, tbl[i].pend);
            check($sformatf("v%0d_fifo_count", i), bus.Fifo_Count, tbl[i].cnt);
            check($sformatf("v%0d_rd_valid", i), bus.Rd_Valid, tbl[i].vld);
            check($sformatf("v%0d_rd_data", i), bus.Rd_Data, tbl[i].rdata);
        end

        // Fill to full, overflow into hold and drops, then drain in order.
        do_reset();
        for (int b = 0; b < 19; b++) begin
            push(b[DB-1:0]);
            idle(3);
        end
        check("full_count", bus.Fifo_Count, ENTRIES);
        check("full_hold", bus.Hold_Full, 1);
        check("full_drop", bus.Drop_Count, exp_drop(2));
        do_read(8'h00, "drain_first");
        idle(3);
        check("refill_count", bus.Fifo_Count, ENTRIES);
        check("refill_hold", bus.Hold_Full, 0);
        for (int b = 1; b <= 16; b++) do_read(b[DB-1:0], $sformatf("drain_%0d", b));
        check("drained_count", bus.Fifo_Count, 0);

        // Write/read contest with count 3 and last grant = read: write wins.
        do_reset();
        for (int b = 0; b < 4; b++) begin
            push(8'h31 + b[DB-1:0]);
            idle(3);
        end
        do_read(8'h31, "contest_pre");
        bus.Rx_Valid = 1; bus.Rx_Data = 8'h35; bus.Rd_Req = 1;
        tick();
        clear_inputs();
        check("contest_setup", {bus.Hold_Full, bus.Rd_Pending, 3'(bus.Fifo_Count)}, {2'b11, 3'd3});
        tick(); check("contest_wr_first", {bus.Fifo_Data_Rdy, bus.Fifo_Pop_Data}, 2'b10);
        tick(); check("contest_gap1", {bus.Fifo_Data_Rdy, bus.Fifo_Pop_Data}, 2'b00);
        tick(); check("contest_gap2", {bus.Fifo_Data_Rdy, bus.Fifo_Pop_Data}, 2'b00);
        tick(); check("contest_rd_next", {bus.Fifo_Data_Rdy, bus.Fifo_Pop_Data}, 2'b01);
        idle(3);
        check("contest_rd_valid", bus.Rd_Valid, 1);
        check("contest_rd_data", bus.Rd_Data, 8'h32);

        // BIST request raised mid-write takes effect only back in IDLE.
        do_reset();
        push(8'h5A);
        tick(); check("bist_wr_pulse", bus.Fifo_Data_Rdy, 1);
        bus.Bist_Req = 1;
        tick(); check("bist_hold_gap", bus.Fifo_BIST_Mode, 0);
        tick(); check("bist_hold_idle", bus.Fifo_BIST_Mode, 0);
        tick(); check("bist_set", bus.Fifo_BIST_Mode, 1);
        push(8'h6B);
        bus.Rd_Req = 1;
        tick();
        bus.Rd_Req = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("bist_no_pulse", {bus.Fifo_Data_Rdy, bus.Fifo_Pop_Data}, 2'b00);
        end
        check("bist_latched", {bus.Hold_Full, bus.Rd_Pending, 3'(bus.Fifo_Count)}, {2'b11, 3'd1});
        bus.Bist_Req = 0;
        tick(); check("bist_clear", bus.Fifo_BIST_Mode, 0);
        tick(); check("bist_resume_pop", bus.Fifo_Pop_Data, 1);
        idle(3);
        check("bist_rd_data", {bus.Rd_Valid, bus.Rd_Data}, {1'b1, 8'h5A});

        // Reset during RD_GAP abandons the read.
        do_reset();
        push(8'h77);
        idle(3);
        bus.Rd_Req = 1;
        tick();
        bus.Rd_Req = 0;
        tick(); check("rstgap_pop", bus.Fifo_Pop_Data, 1);
        tick(); check("rstgap_in_gap", bus.Fifo_Pop_Data, 0);
        rst = 1;
        tick();
        rst = 0;
        check("rstgap_state", {bus.Rd_Valid, bus.Rd_Pending, bus.Fifo_Data_Rdy, bus.Fifo_Pop_Data,
                               bus.Hold_Full, 5'(bus.Fifo_Count)}, 0);
        tick();
        check("rstgap_no_valid", {bus.Rd_Valid, bus.Rd_Pending, 5'(bus.Fifo_Count)}, 0);

        // Random traffic against the reference model, varying write/read pressure.
        do_reset();
        cmp_model = 1;
        for (int c = 0; c < 4000; c++) begin
            int wr_pct, rd_pct;
            wr_pct = (c < 2000) ? 45 : 20;
            rd_pct = (c < 2000) ? 15 : 40;
            bus.Rx_Valid = ($urandom_range(99) < wr_pct);
            bus.Rx_Data  = DB'($urandom);
            bus.Rd_Req   = ($urandom_range(99) < rd_pct);
            if ($urandom_range(99) < 2) bus.Bist_Req = ~bus.Bist_Req;
            tick();
        end
        cmp_model = 0;
        clear_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
